// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between the register decode and the UART TX FIFO.
//   wr_valid : push request (master -> slave)
//   wr_data  : character to enqueue (master -> slave)
//   wr_ready : FIFO not full (slave -> master)
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO, elaboration-time data/stop width and a
// sticky completion flag plus IRQ raised once the FIFO has drained.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_mode port and a
// run-time selectable parity bit (01 even, 10 odd, 00/11 none).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   division     : bit period minus one, in clk cycles (latched per frame)
//   parity_mode  : parity select (only with UART_TX_PARITY_EN)
//   wr           : push handshake (wr_valid/wr_data/wr_ready)
//   level        : FIFO occupancy
//   busy         : serialiser active
//   irq_enable   : IRQ mask
//   flag_clear   : clears done_flag
//   done_flag    : sticky completion flag
//   irq          : done_flag & irq_enable
//   tx           : serial line, idles high
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DIV_WIDTH-1:0]               division,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                         parity_mode,
`endif
  uart_tx_fifo_if.slave                      wr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               busy,
  input  logic                               irq_enable,
  input  logic                               flag_clear,
  output logic                               done_flag,
  output logic                               irq,
  output logic                               tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full_c, push_c, pop_c, tick_c, last_stop_c;
  logic [DATA_BITS-1:0] head_c;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_WIDTH-1:0] div_q, baud_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 done_evt;
  logic                 tx_c;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_bit_q;
`endif

  // FIFO status and handshake, all from registered state
  assign full_c      = (level == LVL_W'(FIFO_DEPTH));
  assign wr.wr_ready = !full_c;
  assign push_c      = wr.wr_valid && !full_c;
  assign head_c      = mem[rd_ptr];
  assign tick_c      = (baud_cnt == div_q);
  assign last_stop_c = (state == S_STOP) && tick_c && (bit_cnt == CNT_W'(STOP_BITS - 1));
  assign pop_c       = ((state == S_IDLE) || last_stop_c) && (level != '0);
  assign irq         = done_flag & irq_enable;

  // FIFO storage (no reset needed on the data array)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr.wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      level <= level + LVL_W'(1);
      else if (!push_c && pop_c) level <= level - LVL_W'(1);
    end
  end

  // Line value for the current internal state
  always_comb begin
    tx_c = 1'b1;
    case (state)
      S_START:  tx_c = 1'b0;
      S_DATA:   tx_c = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_c = par_bit_q;
`endif
      default:  tx_c = 1'b1;
    endcase
  end

  // Serialiser FSM; tx/busy/done_flag are registered one cycle behind state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      div_q     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      done_evt  <= 1'b0;
      done_flag <= 1'b0;
      busy      <= 1'b0;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      tx       <= tx_c;
      busy     <= (state != S_IDLE);
      done_evt <= 1'b0;
      // set wins over a coincident clear
      if (done_evt)        done_flag <= 1'b1;
      else if (flag_clear) done_flag <= 1'b0;

      if (pop_c) begin
        state    <= S_START;
        shreg    <= head_c;
        div_q    <= division;
        baud_cnt <= '0;
        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= parity_mode[0] ^ parity_mode[1];
        par_bit_q <= (^head_c) ^ parity_mode[1];
`endif
      end else begin
        case (state)
          S_IDLE: ;
          S_START: begin
            if (tick_c) begin
              baud_cnt <= '0;
              state    <= S_DATA;
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
          S_DATA: begin
            if (tick_c) begin
              baud_cnt <= '0;
              shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
              if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                state   <= par_en_q ? S_PARITY : S_STOP;
`else
                state   <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (tick_c) begin
              baud_cnt <= '0;
              state    <= S_STOP;
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
`endif
          S_STOP: begin
            if (tick_c) begin
              baud_cnt <= '0;
              if (last_stop_c) begin
                // FIFO empty here, otherwise pop_c would have restarted
                state    <= S_IDLE;
                done_evt <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It buffers outgoing characters in a FIFO and has a configurable frame format: data width and stop-bit count are fixed at elaboration, parity is selected at run time. Each character is serialised LSB first on `tx`. A sticky completion flag and an IRQ fire when the FIFO has drained and the last stop bit has ended. The block sits behind the peripheral's bus register decode, and the decode drives the write and configuration ports.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
DIV_WIDTH, 16, width of the baud divisor.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
division  in  DIV_WIDTH  bit period minus one, in clk cycles.
parity_mode  in  2  00 = none, 01 = even, 10 = odd, 11 = none (present only with the optional feature).
wr_valid  in  1  push request.
wr_data  in  DATA_BITS  character to send.
wr_ready  out  1  FIFO not full.
level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
busy  out  1  serialiser not in IDLE.
irq_enable  in  1  IRQ mask.
flag_clear  in  1  clears done_flag.
done_flag  out  1  sticky completion flag.
irq  out  1  done_flag & irq_enable.
tx  out  1  serial line; idles high.

Behaviour:
- Reset values: tx=1, busy=0, level=0, wr_ready=1, done_flag=0, irq=0. The FIFO is emptied and the state is IDLE. Reset mid-frame aborts the frame: tx=1 after the reset edge and no flag is set.
- Push: occurs when wr_valid && wr_ready at a rising edge.
  - wr_ready = !full, and depends only on registered state.
  - A push while full is dropped with no side effects.
- Pop: the serialiser pops only when in IDLE (or at the end of STOP) and level != 0, using registered level.
  - A push and a pop in the same cycle leave level unchanged.
  - A push into an empty FIFO is not popped in the same cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. level counts 0..FIFO_DEPTH.
- State machine IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE, or START if level != 0).
  - The pop into START latches the character, division and parity_mode. Later changes to those inputs affect only the next frame.
  - Every bit (start, data, parity, stop) holds tx for exactly division+1 clk cycles. division=0 gives 1 cycle per bit.
  - The bit counter counts DATA_BITS data bits, sent LSB first, then STOP_BITS stop bits (tx=1).
  - Back-to-back frames: the next start bit immediately follows the last stop-bit cycle, with no idle gap.
- Latency: a character accepted at edge k into an empty FIFO with the serialiser idle drives tx=0 from edge k+2. busy=1 from edge k+2 to the end of the last stop bit.
- done_flag:
  - Set on the edge that ends the final stop-bit cycle, if no further character is popped at that edge.
  - If flag_clear and the set event coincide, set wins.
  - Otherwise flag_clear clears the flag on the next edge.
  - irq is combinational from registered done_flag and irq_enable.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the parity_mode port exists. Modes 01/10 insert one parity bit after the data bits, lasting division+1 cycles.
  - Even parity: the parity bit makes the total number of ones in the data plus parity even.
  - Odd parity: it makes the total odd.
  - Mode 11 behaves like 00.
- Undefined: the port is absent, there is no PARITY state, and frames are always 1 + DATA_BITS + STOP_BITS bits.

Test Plan:
1. Reset:
   - Stimulus: hold reset 1 cycle, release.
   - Response: tx=1, wr_ready=1, level=0, done_flag=0, irq=0.
2. Single frame:
   - Stimulus: division=3, DATA_BITS=8, STOP_BITS=1; push 0x53.
   - Response: tx=0 from edge k+2 for 4 cycles, then bits 1,1,0,0,1,0,1,0 for 4 cycles each, then stop=1 for 4 cycles. done_flag rises after 40 cycles of frame, irq stays 0 with irq_enable=0.
3. Burst and backpressure:
   - Stimulus: FIFO_DEPTH=8; push 10 characters 0x00..0x09 while the serialiser is busy.
   - Response: level peaks at 8, wr_ready=0 while full, and the extra pushes are dropped.
   - Response: the accepted characters go out back-to-back, in order, with no idle gap.
   - Response: done_flag is set once, after the last one.
4. IRQ and clear:
   - Stimulus: irq_enable=1; push 0xCA; wait for completion; pulse flag_clear.
   - Response: irq=1 with done_flag; both 0 one edge after flag_clear.
5. Parity (UART_TX_PARITY_EN defined):
   - Stimulus: push 0x53 with parity_mode=01, then again with 10.
   - Response: parity bit 0 with mode 01 and 1 with mode 10; the frame is 11 bit-times.
6. Mid-frame reset:
   - Stimulus: assert reset during data bit 3 with 2 characters queued.
   - Response: tx=1, level=0, busy=0 after the edge; no frame resumes and done_flag stays 0.
